fifo_prog: RTL and testbench



---
 rtl/fifo_prog.sv | 176 +++++++++++++++++
 tb/tb_fifo_prog.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_prog.sv
// fifo_prog: synchronous show-ahead FIFO with programmable almost-full/almost-empty thresholds.
//
// Parameters
//   WIDTH              data width in bits (>= 1)
//   DEPTH              entry count (>= 2, any integer)
//   ALMOST_FULL_COUNT  almost_full asserts when count >= this value
//   ALMOST_EMPTY_COUNT almost_empty asserts when count <= this value
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   clr                synchronous flush; overrides wr_en and rd_en
//   wr_en, wr_data     write request and data
//   rd_en              read acknowledge (pops the head)
//   rd_data            head-of-queue data, valid whenever empty = 0
//   empty, full        registered status flags
//   almost_empty       registered, count <= ALMOST_EMPTY_COUNT
//   almost_full        registered, count >= ALMOST_FULL_COUNT
//   count, space       registered occupancy and free entries (count + space == DEPTH)
//   overflow           sticky: write attempted but not accepted
//   underflow          sticky: read attempted while empty
//
// Build option
//   FIFO_PROG_STICKY_ERR_EN  when defined, overflow/underflow tracking is built;
//                            otherwise both outputs are tied to 0.

module fifo_prog #(
  parameter int unsigned WIDTH              = 8,
  parameter int unsigned DEPTH              = 16,
  parameter int unsigned ALMOST_FULL_COUNT  = DEPTH,
  parameter int unsigned ALMOST_EMPTY_COUNT = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   empty,
  output logic                   full,
  output logic                   almost_empty,
  output logic                   almost_full,
  output logic [$clog2(DEPTH):0] count,
  output logic [$clog2(DEPTH):0] space,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  localparam ptr_t LastIdx  = ptr_t'(DEPTH - 1);
  localparam cnt_t DepthCnt = cnt_t'(DEPTH);
  localparam logic AfRst    = (ALMOST_FULL_COUNT == 32'd0);

  // Storage has no reset; rd_data is meaningless while empty.
  logic [WIDTH-1:0] mem [DEPTH];

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  cnt_t count_q, count_d;
  cnt_t space_q, space_d;
  logic empty_q, empty_d;
  logic full_q, full_d;
  logic almost_empty_q, almost_empty_d;
  logic almost_full_q, almost_full_d;

  logic valid_wr;
  logic valid_rd;

  // Explicit wrap so non-power-of-two depths work.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == LastIdx) ? '0 : p + ptr_t'(1);
  endfunction

  // A write while full is accepted only when a pop frees the slot in the same cycle.
  assign valid_rd = rd_en & ~empty_q;
  assign valid_wr = wr_en & (~full_q | valid_rd);

  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (valid_wr) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (valid_rd) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({valid_wr, valid_rd})
        2'b10:   count_d = count_q + cnt_t'(1);
        2'b01:   count_d = count_q - cnt_t'(1);
        default: count_d = count_q;
      endcase
    end
    space_d        = DepthCnt - count_d;
    empty_d        = (count_d == '0);
    full_d         = (count_d == DepthCnt);
    almost_full_d  = (32'(count_d) >= ALMOST_FULL_COUNT);
    almost_empty_d = (32'(count_d) <= ALMOST_EMPTY_COUNT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      space_q        <= DepthCnt;
      empty_q        <= 1'b1;
      full_q         <= 1'b0;
      almost_empty_q <= 1'b1;
      almost_full_q  <= AfRst;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      space_q        <= space_d;
      empty_q        <= empty_d;
      full_q         <= full_d;
      almost_empty_q <= almost_empty_d;
      almost_full_q  <= almost_full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (valid_wr && !clr) mem[wr_ptr_q] <= wr_data;
  end

  // Asynchronous read gives show-ahead behaviour: the head appears as soon as
  // rd_ptr or the addressed entry changes, including a write to the prefetch slot.
  assign rd_data      = mem[rd_ptr_q];
  assign count        = count_q;
  assign space        = space_q;
  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_empty = almost_empty_q;
  assign almost_full  = almost_full_q;

`ifdef FIFO_PROG_STICKY_ERR_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_en && !valid_wr) overflow_d  = 1'b1;
      if (rd_en && empty_q)   underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_prog.sv
module tb_fifo_prog;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 5;
  localparam int unsigned AFC   = 4;
  localparam int unsigned AEC   = 1;

  logic             clk;
  logic             rst;
  logic             clr;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             empty;
  logic             full;
  logic             almost_empty;
  logic             almost_full;
  logic [3:0]       count;
  logic [3:0]       space;
  logic             overflow;
  logic             underflow;

  fifo_prog #(
    .WIDTH             (WIDTH),
    .DEPTH             (DEPTH),
    .ALMOST_FULL_COUNT (AFC),
    .ALMOST_EMPTY_COUNT(AEC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clr         (clr),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .empty       (empty),
    .full        (full),
    .almost_empty(almost_empty),
    .almost_full (almost_full),
    .count       (count),
    .space       (space),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef FIFO_PROG_STICKY_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  int n_total = 0;
  int n_bad   = 0;

  // Reference model
  logic [WIDTH-1:0] sb[$];
  int unsigned      m_count;
  bit               m_ov;
  bit               m_un;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_status(input string tag);
    check_eq({tag, ".count"}, 32'(count), m_count);
    check_eq({tag, ".space"}, 32'(space), DEPTH - m_count);
    check_eq({tag, ".empty"}, 32'(empty), 32'(m_count == 0));
    check_eq({tag, ".full"}, 32'(full), 32'(m_count == DEPTH));
    check_eq({tag, ".aempty"}, 32'(almost_empty), 32'(m_count <= AEC));
    check_eq({tag, ".afull"}, 32'(almost_full), 32'(m_count >= AFC));
    check_eq({tag, ".ovf"}, 32'(overflow), 32'(m_ov));
    check_eq({tag, ".unf"}, 32'(underflow), 32'(m_un));
    if (m_count != 0) check_eq({tag, ".head"}, 32'(rd_data), 32'(sb[0]));
  endtask

  // One clock cycle; called at posedge+1, returns at the next posedge+1 after checking.
  task automatic cycle(input string tag, input bit w, input logic [WIDTH-1:0] d,
                       input bit r, input bit c);
    bit vr;
    bit vw;
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    clr     = c;
    vr = r && (m_count != 0);
    vw = w && ((m_count != DEPTH) || vr);
    @(posedge clk);
    #1;
    if (c) begin
      sb.delete();
      m_count = 0;
      m_ov    = 1'b0;
      m_un    = 1'b0;
    end else begin
      if (ErrEn && w && !vw) m_ov = 1'b1;
      if (ErrEn && r && (m_count == 0)) m_un = 1'b1;
      if (vr) void'(sb.pop_front());
      if (vw) sb.push_back(d);
      m_count = sb.size();
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    clr   = 1'b0;
    check_status(tag);
  endtask

  task automatic model_reset();
    sb.delete();
    m_count = 0;
    m_ov    = 1'b0;
    m_un    = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    clr     = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    rd_en   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_status("reset");
    rst = 1'b0;

    // Fill to full; almost_empty falls after 2nd, almost_full rises after 4th
    for (int i = 1; i <= 5; i++) cycle("fill", 1'b1, 8'(i), 1'b0, 1'b0);
    // Write while full without read: dropped
    cycle("wr_full", 1'b1, 8'h77, 1'b0, 1'b0);
    // Simultaneous write/read while full
    cycle("full_rw", 1'b1, 8'hAA, 1'b1, 1'b0);
    // Drain: 02..05 then AA
    for (int i = 0; i < 5; i++) cycle("drain", 1'b0, 8'h00, 1'b1, 1'b0);
    check_eq("drained_empty", 32'(empty), 32'd1);
    // Read+write while empty: read ignored, write accepted
    cycle("empty_rw", 1'b1, 8'h3C, 1'b1, 1'b0);
    check_eq("empty_rw_data", 32'(rd_data), 32'h3C);
    check_eq("empty_rw_unf", 32'(underflow), 32'(ErrEn));
    // Three entries, then clr with a concurrent write
    cycle("pre_clr", 1'b1, 8'h41, 1'b0, 1'b0);
    cycle("pre_clr", 1'b1, 8'h42, 1'b0, 1'b0);
    cycle("clr", 1'b1, 8'h99, 1'b1, 1'b1);
    check_eq("clr_count", 32'(count), 32'd0);
    check_eq("clr_space", 32'(space), 32'd5);
    // Post-clear write shows up after one cycle at the head
    cycle("post_clr", 1'b1, 8'h55, 1'b0, 1'b0);
    check_eq("post_clr_data", 32'(rd_data), 32'h55);

    // Random traffic to exercise wrap and prefetch-address collisions
    for (int i = 0; i < 300; i++)
      cycle("rand", ($urandom_range(0, 99) < 55), 8'($urandom), ($urandom_range(0, 99) < 50),
            ($urandom_range(0, 99) < 2));

    // Mid-burst asynchronous reset
    cycle("burst", 1'b1, 8'hC1, 1'b0, 1'b0);
    cycle("burst", 1'b1, 8'hC2, 1'b0, 1'b0);
    wr_en   = 1'b1;
    wr_data = 8'hC3;
    #1;
    rst = 1'b1;
    #1;
    model_reset();
    check_status("async_rst");
    wr_en = 1'b0;
    @(posedge clk);
    #1;
    check_status("rst_held");
    rst = 1'b0;
    cycle("post_rst", 1'b1, 8'h09, 1'b0, 1'b0);
    check_eq("post_rst_data", 32'(rd_data), 32'h09);
    cycle("post_rst_pop", 1'b0, 8'h00, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
